// File: rtl/wordle_pkg.sv
// Shared constants for the Wordle scorer: word geometry, colour codes and one-hot state encoding.
package wordle_pkg;
    localparam int LETTERS     = 5;
    localparam int LETTER_W    = 8;
    localparam int MAX_GUESSES = 6;

    localparam logic [1:0] GREY   = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;

    typedef enum logic [5:0] {
        S_IDLE   = 6'b000001,
        S_GREEN  = 6'b000010,
        S_YELLOW = 6'b000100,
        S_COMMIT = 6'b001000,
        S_DONE   = 6'b010000,
        S_REJECT = 6'b100000
    } state_t;
endpackage

// File: rtl/wordle_letter_match.sv
// Finds the lowest-index unused answer position holding a given letter.
module wordle_letter_match #(
    parameter int LETTERS  = 5,
    parameter int LETTER_W = 8
) (
    input  logic [LETTER_W-1:0]         letter,
    input  logic [LETTERS*LETTER_W-1:0] answer,
    input  logic [LETTERS-1:0]          used,
    output logic                        hit,
    output logic [LETTERS-1:0]          pos_oh
);
    always_comb begin
        hit    = 1'b0;
        pos_oh = '0;
        // Scan from the last position down so the lowest index wins.
        for (int p = LETTERS - 1; p >= 0; p--) begin
            if (!used[p] && answer[(LETTERS-1-p)*LETTER_W +: LETTER_W] == letter) begin
                hit       = 1'b1;
                pos_oh    = '0;
                pos_oh[p] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/wordle_scorer.sv
// Multi-cycle Wordle guess scorer with guess count and win/lose tracking.
// Optional hard mode (green letters must be reused) under WORDLE_HARD_MODE_EN.
module wordle_scorer
    import wordle_pkg::*;
(
    input  logic                        Clk,
    input  logic                        reset,
    input  logic                        new_game,
    input  logic                        start,
    input  logic [LETTERS*LETTER_W-1:0] guess,
    input  logic [LETTERS*LETTER_W-1:0] answer,
    output logic                        busy,
    output logic                        done,
    output logic [2*LETTERS-1:0]        colors,
    output logic [2:0]                  guess_num,
    output logic                        win,
    output logic                        lose,
    output logic                        reject
);
    localparam int IDX_W = $clog2(LETTERS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LETTERS - 1);
    localparam logic [2:0] MAX_NUM = 3'(MAX_GUESSES);

    state_t                        state;
    logic [IDX_W-1:0]              idx;
    logic [LETTERS-1:0]            used;
    logic [1:0]                    wcode [LETTERS];
    logic [LETTERS*LETTER_W-1:0]   g_q, a_q;
    logic [LETTER_W-1:0]           cur_g, cur_a;
    logic [2*LETTERS-1:0]          wpack;
    logic                          all_green;
    logic [2:0]                    next_num;
    logic                          m_hit;
    logic [LETTERS-1:0]            m_oh;
    logic                          hard_viol;

    always_comb begin
        cur_g     = '0;
        cur_a     = '0;
        wpack     = '0;
        all_green = 1'b1;
        for (int p = 0; p < LETTERS; p++) begin
            if (idx == IDX_W'(p)) begin
                cur_g = g_q[(LETTERS-1-p)*LETTER_W +: LETTER_W];
                cur_a = a_q[(LETTERS-1-p)*LETTER_W +: LETTER_W];
            end
            wpack[(LETTERS-1-p)*2 +: 2] = wcode[p];
            if (wcode[p] != GREEN) all_green = 1'b0;
        end
        next_num = (guess_num == MAX_NUM) ? guess_num : guess_num + 3'd1;
    end

    wordle_letter_match #(.LETTERS(LETTERS), .LETTER_W(LETTER_W)) u_match (
        .letter (cur_g),
        .answer (a_q),
        .used   (used),
        .hit    (m_hit),
        .pos_oh (m_oh)
    );

`ifdef WORDLE_HARD_MODE_EN
    logic [LETTERS*LETTER_W-1:0] hist_g;
    logic [2*LETTERS-1:0]        hist_c;

    // A guess is refused if any previously green position changed letter.
    always_comb begin
        hard_viol = 1'b0;
        for (int p = 0; p < LETTERS; p++)
            if (hist_c[(LETTERS-1-p)*2 +: 2] == GREEN &&
                guess[(LETTERS-1-p)*LETTER_W +: LETTER_W] != hist_g[(LETTERS-1-p)*LETTER_W +: LETTER_W])
                hard_viol = 1'b1;
    end
`else
    assign hard_viol = 1'b0;
    assign reject    = 1'b0;
`endif

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            colors    <= '0;
            guess_num <= '0;
            win       <= 1'b0;
            lose      <= 1'b0;
            idx       <= '0;
            used      <= '0;
            g_q       <= '0;
            a_q       <= '0;
            for (int p = 0; p < LETTERS; p++) wcode[p] <= GREY;
`ifdef WORDLE_HARD_MODE_EN
            reject    <= 1'b0;
            hist_g    <= '0;
            hist_c    <= '0;
`endif
        end else begin
            done <= 1'b0;
`ifdef WORDLE_HARD_MODE_EN
            reject <= 1'b0;
`endif
            if (new_game) begin
                state     <= S_IDLE;
                busy      <= 1'b0;
                colors    <= '0;
                guess_num <= '0;
                win       <= 1'b0;
                lose      <= 1'b0;
`ifdef WORDLE_HARD_MODE_EN
                hist_g    <= '0;
                hist_c    <= '0;
`endif
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !win && !lose) begin
                            g_q   <= guess;
                            a_q   <= answer;
                            idx   <= '0;
                            used  <= '0;
                            busy  <= 1'b1;
                            for (int p = 0; p < LETTERS; p++) wcode[p] <= GREY;
                            state <= hard_viol ? S_REJECT : S_GREEN;
                        end
                    end
                    S_GREEN: begin
                        if (cur_g == cur_a) begin
                            wcode[idx] <= GREEN;
                            used[idx]  <= 1'b1;
                        end
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= S_YELLOW;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    S_YELLOW: begin
                        if (wcode[idx] != GREEN && m_hit) begin
                            wcode[idx] <= YELLOW;
                            used       <= used | m_oh;
                        end
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= S_COMMIT;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    S_COMMIT: begin
                        colors    <= wpack;
                        guess_num <= next_num;
                        win       <= all_green;
                        lose      <= !all_green && (next_num == MAX_NUM);
                        done      <= 1'b1;
                        state     <= S_DONE;
`ifdef WORDLE_HARD_MODE_EN
                        hist_g    <= g_q;
                        hist_c    <= wpack;
`endif
                    end
                    S_DONE: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    S_REJECT: begin
`ifdef WORDLE_HARD_MODE_EN
                        reject <= 1'b1;
`endif
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_wordle_scorer.sv
// Scoreboard bench for wordle_scorer: reference scoring model, latency and game-state checks.
module tb_wordle_scorer;
    logic        Clk = 1'b0;
    logic        reset = 1'b1;
    logic        new_game = 1'b0;
    logic        start = 1'b0;
    logic [39:0] guess = '0;
    logic [39:0] answer = '0;
    logic        busy, done, win, lose, reject;
    logic [9:0]  colors;
    logic [2:0]  guess_num;

    wordle_scorer dut (
        .Clk(Clk), .reset(reset), .new_game(new_game), .start(start),
        .guess(guess), .answer(answer), .busy(busy), .done(done),
        .colors(colors), .guess_num(guess_num), .win(win), .lose(lose),
        .reject(reject)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [9:0] c;
        logic       w;
        logic       l;
        logic [2:0] n;
        int         t0;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          m_num = 0;
    logic        m_win = 1'b0;
    logic        m_lose = 1'b0;
    logic [39:0] m_hist_g = '0;
    logic [9:0]  m_hist_c = '0;

    always @(posedge Clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Count-based scoring: greens first, then yellows consume remaining answer letters.
    function automatic logic [9:0] ref_score(input logic [39:0] g, input logic [39:0] a);
        int         cnt [256];
        logic [7:0] gl, al;
        logic [9:0] r = '0;
        for (int i = 0; i < 256; i++) cnt[i] = 0;
        for (int i = 0; i < 5; i++) begin
            gl = g[39-8*i -: 8];
            al = a[39-8*i -: 8];
            if (gl == al) r[9-2*i -: 2] = 2'b10;
            else cnt[al]++;
        end
        for (int i = 0; i < 5; i++) begin
            gl = g[39-8*i -: 8];
            if (r[9-2*i -: 2] != 2'b10 && cnt[gl] > 0) begin
                r[9-2*i -: 2] = 2'b01;
                cnt[gl]--;
            end
        end
        return r;
    endfunction

    function automatic logic hard_ok(input logic [39:0] g);
        logic ok = 1'b1;
`ifdef WORDLE_HARD_MODE_EN
        for (int i = 0; i < 5; i++)
            if (m_hist_c[9-2*i -: 2] == 2'b10 && g[39-8*i -: 8] != m_hist_g[39-8*i -: 8]) ok = 1'b0;
`else
        ok = (g == g);
`endif
        return ok;
    endfunction

    always @(negedge Clk) begin
        if (done) begin
            if (sb.size() == 0) chk("spurious_done", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("colors", 32'(colors), 32'(e.c));
                chk("win", 32'(win), 32'(e.w));
                chk("lose", 32'(lose), 32'(e.l));
                chk("guess_num", 32'(guess_num), 32'(e.n));
                chk("latency", 32'(cyc - e.t0), 32'd12);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy || sb.size() != 0) && n < 40) begin
            @(negedge Clk);
            n++;
        end
        chk("idle_timeout", 32'(n < 40), 1);
    endtask

    task automatic issue(input logic [39:0] g, input logic [39:0] a);
        logic       acc, rej;
        logic [9:0] c;
        exp_t       e;
        @(negedge Clk);
        acc = !m_win && !m_lose && hard_ok(g);
        rej = !m_win && !m_lose && !hard_ok(g);
        guess = g; answer = a; start = 1'b1;
        if (acc) begin
            c = ref_score(g, a);
            m_num  = (m_num == 6) ? 6 : m_num + 1;
            m_win  = (c == 10'b1010101010);
            m_lose = !m_win && (m_num == 6);
            m_hist_g = g; m_hist_c = c;
            e.c = c; e.w = m_win; e.l = m_lose; e.n = 3'(m_num); e.t0 = cyc;
            sb.push_back(e);
        end
        @(negedge Clk);
        start = 1'b0;
        guess = 40'({$urandom(), $urandom()});
        answer = 40'({$urandom(), $urandom()});
        if (rej) begin
            @(negedge Clk);
            chk("reject", 32'(reject), 1);
            chk("rej_num", 32'(guess_num), 32'(m_num));
        end else if (!acc) begin
            chk("ignored_busy", 32'(busy), 0);
        end
    endtask

    task automatic do_new_game();
        @(negedge Clk); new_game = 1'b1;
        @(negedge Clk); new_game = 1'b0;
        m_num = 0; m_win = 1'b0; m_lose = 1'b0; m_hist_g = '0; m_hist_c = '0;
    endtask

    function automatic logic [39:0] rand_word();
        logic [39:0] w;
        for (int i = 0; i < 5; i++) w[39-8*i -: 8] = 8'h41 + 8'($urandom_range(0, 2));
        return w;
    endfunction

    initial begin
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_colors", 32'(colors), 0);
        chk("rst_num", 32'(guess_num), 0);
        chk("rst_winlose", 32'({win, lose, reject}), 0);
        repeat (2) @(negedge Clk);
        reset = 1'b0;

        issue("ROBOT", "ROBOT");
        wait_idle();
        chk("win_sticky", 32'(win), 1);
        issue("ROBIN", "ROBOT");
        wait_idle();
        do_new_game();
        chk("ng_win", 32'(win), 0);

        issue("ROBOT", "ROBIN"); wait_idle();
        issue("BANAL", "ABBOT"); wait_idle();
        do_new_game();

        for (int k = 0; k < 7; k++) begin
            issue("CACAO", "MINUS");
            wait_idle();
        end
        chk("lose_num", 32'(guess_num), 6);
        chk("lose_flag", 32'(lose), 1);
        do_new_game();
        chk("ng_num", 32'(guess_num), 0);
        chk("ng_lose", 32'(lose), 0);

        // Reset in the middle of scoring aborts it without a done pulse.
        issue("ROBIN", "ROBOT");
        repeat (3) @(negedge Clk);
        #1 reset = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_colors", 32'(colors), 0);
        chk("arst_num", 32'(guess_num), 0);
        sb.delete();
        m_num = 0; m_win = 1'b0; m_lose = 1'b0; m_hist_g = '0; m_hist_c = '0;
        @(negedge Clk); reset = 1'b0;
        repeat (15) @(negedge Clk);
        issue("TOBOR", "ROBOT"); wait_idle();

        // new_game mid-scoring aborts; new_game with start drops the start.
        issue("OTTER", "ROBOT");
        sb.delete();
        do_new_game();
        @(negedge Clk);
        chk("abort_busy", 32'(busy), 0);
        @(negedge Clk); new_game = 1'b1; start = 1'b1; guess = "ROBOT"; answer = "ROBOT";
        @(negedge Clk); new_game = 1'b0; start = 1'b0;
        chk("ng_start_busy", 32'(busy), 0);
        repeat (14) @(negedge Clk);

        for (int k = 0; k < 12; k++) begin
            if (k % 4 == 0) do_new_game();
            issue(rand_word(), rand_word());
            wait_idle();
        end

`ifdef WORDLE_HARD_MODE_EN
        do_new_game();
        issue("ROBIN", "ROBOT"); wait_idle();
        issue("RABBI", "ROBOT"); wait_idle();
        chk("hard_num", 32'(guess_num), 1);
        issue("ROBES", "ROBOT"); wait_idle();
        chk("hard_num2", 32'(guess_num), 2);
`endif

        repeat (3) @(negedge Clk);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got 1 exp 0");
        $fatal(1);
    end
endmodule
